if_id_frontend: RTL and testbench
=================================

IF_ID_FRONTEND -- requirements
Module: if_id_frontend

Interface
REQ-001 Parameter INIT_FILE, default "" (empty), meaning: hex file loaded into the instruction ROM; empty selects the built-in default contents.
REQ-002 Parameter PC_W, default 8, meaning: program-counter width; ROM depth is 2^PC_W.
REQ-003 Parameter INSTR_W, default 20, meaning: instruction width; the design SHALL be verified only at the default widths.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 stall  input  1  high = freeze PC and the IF/ID register.
REQ-007 pc_if  output  8  current IF-stage PC.
REQ-008 instr_if  output  20  ROM word at pc_if.
REQ-009 pc_id  output  8  PC held in the IF/ID register.
REQ-010 instr_id  output  20  instruction held in the IF/ID register.
REQ-011 valid_id  output  1  IF/ID register holds a fetched instruction.
REQ-012 opcode  output  4  decoded instr_id[19:16].
REQ-013 A  output  8  decoded instr_id[15:8].
REQ-014 B  output  8  decoded instr_id[7:0].

Function
REQ-015 The IF stage SHALL hold an 8-bit PC register; when stall=0, the PC SHALL update to pc+1 on every rising edge, wrapping from 255 to 0.
REQ-016 When stall=1, the PC SHALL hold its value.
REQ-017 instr_if SHALL be a combinational (zero-latency) read of ROM[pc_if].
REQ-018 With INIT_FILE empty, ROM[i] SHALL equal {i[3:0], i[7:0], 8'hFF - i[7:0]}.
REQ-019 The ROM SHALL be read-only; it SHALL have no write port.
REQ-020 When stall=0, the IF/ID register SHALL capture pc_if, instr_if and valid=1 on each rising edge.
REQ-021 The IF/ID latency SHALL be exactly one cycle; after each unstalled edge, pc_id equals pc_if - 1 (mod 256).
REQ-022 When stall=1, pc_id, instr_id and valid_id SHALL hold their values.
REQ-023 The ID stage SHALL be purely combinational from instr_id: opcode=instr_id[19:16], A=instr_id[15:8], B=instr_id[7:0].
REQ-024 The ID stage SHALL perform no further decoding; the opcode meaning belongs to downstream stages.
REQ-025 If stall is asserted on the first edge after reset release, the IF/ID register SHALL hold its reset contents (valid_id=0).

Reset
REQ-026 When rstn=0, the design SHALL asynchronously force pc_if=0.
REQ-027 When rstn=0, the design SHALL asynchronously force pc_id=0, instr_id=0 and valid_id=0.
REQ-028 During reset, opcode, A and B SHALL read 0, and instr_if SHALL read ROM[0].
REQ-029 Reset SHALL take precedence over stall.
REQ-030 Assertion of reset mid-operation SHALL return all registers to their reset values immediately, without waiting for a clock edge.
REQ-031 After rstn rises, the first rising edge SHALL load pc_if=1, pc_id=0 and instr_id=ROM[0].

Structure
REQ-032 A shared package SHALL hold PC_W, INSTR_W, the opcode field bounds [19:16], the A field bounds [15:8], the B field bounds [7:0] and the reset PC value 0.
REQ-033 The top level SHALL instantiate three sub-modules: if_stage (PC register and ROM), pipe_if_id (pipeline register) and id_stage (field split).
REQ-034 if_stage SHALL have ports clk, rstn, stall, pc_out and instr_out.
REQ-035 pipe_if_id SHALL have ports clk, rstn, stall, pc_in, instr_in, pc_out and instr_out.
REQ-036 id_stage SHALL have ports instr, opcode, A and B.
REQ-037 There SHALL be no logic at the top level beyond interconnect.

Verification
REQ-038 Reset test: hold rstn=0 for 20 ns -> pc_if=0, pc_id=0, instr_id=0, valid_id=0, instr_if=20'h000FF.
REQ-039 Free-run test: release reset, stall=0, run 40 rising edges -> pc_if=40, instr_if=20'h828D7, pc_id=39, opcode=4'h7, A=8'h27, B=8'hD8.
REQ-040 Wrap test: run 256 unstalled edges after reset -> pc_if=0, pc_id=255, instr_id=20'hFFF00.
REQ-041 Stall test: assert stall at pc_if=10 for 3 edges -> pc_if stays 10 and pc_id stays 9; deassert stall -> pc_if=11 after one edge.
REQ-042 Asynchronous-reset test: drop rstn mid-cycle at pc_if=25 -> all registered outputs read 0 before the next clock edge.
REQ-043 Reset-versus-stall test: rstn=0 with stall=1 -> registers reset to 0.

Source files
------------

// File: rtl/if_id_frontend_pkg.sv
// Shared widths, field bounds and reset values for the IF/ID front end.
package if_id_frontend_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 20;

  localparam int OPC_HI = 19;
  localparam int OPC_LO = 16;
  localparam int A_HI   = 15;
  localparam int A_LO   = 8;
  localparam int B_HI   = 7;
  localparam int B_LO   = 0;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  // Built-in ROM image: low nibble of the address as opcode, the address
  // itself as field A and its bitwise complement as field B.
  function automatic logic [INSTR_W-1:0] default_rom_word(input logic [PC_W-1:0] addr);
    return {addr[3:0], addr, 8'hFF - addr};
  endfunction

endpackage

// File: rtl/if_id_frontend_id_stage.sv
// Decode stage: pure field split of the held instruction, no interpretation.
module id_stage
  import if_id_frontend_pkg::*;
#(
  parameter int INSTR_W = if_id_frontend_pkg::INSTR_W
) (
  input  logic [INSTR_W-1:0]       instr,
  output logic [OPC_HI-OPC_LO:0]   opcode,
  output logic [A_HI-A_LO:0]       A,
  output logic [B_HI-B_LO:0]       B
);

  assign opcode = instr[OPC_HI:OPC_LO];
  assign A      = instr[A_HI:A_LO];
  assign B      = instr[B_HI:B_LO];

endmodule

// File: rtl/if_id_frontend_if_stage.sv
// Fetch stage: free-running PC with stall, and a read-only instruction ROM
// read combinationally at the current PC.
module if_stage
  import if_id_frontend_pkg::*;
#(
  parameter string INIT_FILE = "",
  parameter int    PC_W      = if_id_frontend_pkg::PC_W,
  parameter int    INSTR_W   = if_id_frontend_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out
);

  logic [PC_W-1:0] pc_q;

  // PC advances by one each unstalled edge and wraps naturally at 2^PC_W.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= PC_W'(RESET_PC);
    end else if (!stall) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  assign pc_out = pc_q;

  // Read-only ROM built from the arithmetic default image.
  assign instr_out = INSTR_W'(default_rom_word(8'(pc_q)));

endmodule

// File: rtl/if_id_frontend_pipe_if_id.sv
// IF/ID pipeline register: one-cycle hand-off of PC, instruction and valid.
module pipe_if_id
  import if_id_frontend_pkg::*;
#(
  parameter int PC_W    = if_id_frontend_pkg::PC_W,
  parameter int INSTR_W = if_id_frontend_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stall,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;

  // Capture the fetch outputs on every unstalled edge; hold while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= 1'b1;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_id_frontend.sv
// Two-stage fetch/decode front end: fetch, IF/ID register, field split.
module if_id_frontend
  import if_id_frontend_pkg::*;
#(
  parameter string INIT_FILE = "",
  parameter int    PC_W      = if_id_frontend_pkg::PC_W,
  parameter int    INSTR_W   = if_id_frontend_pkg::INSTR_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     stall,
  output logic [PC_W-1:0]          pc_if,
  output logic [INSTR_W-1:0]       instr_if,
  output logic [PC_W-1:0]          pc_id,
  output logic [INSTR_W-1:0]       instr_id,
  output logic                     valid_id,
  output logic [OPC_HI-OPC_LO:0]   opcode,
  output logic [A_HI-A_LO:0]       A,
  output logic [B_HI-B_LO:0]       B
);

  if_stage #(
    .INIT_FILE (INIT_FILE),
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W)
  ) u_if_stage (
    .clk       (clk),
    .rstn      (rstn),
    .stall     (stall),
    .pc_out    (pc_if),
    .instr_out (instr_if)
  );

  pipe_if_id #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_pipe_if_id (
    .clk       (clk),
    .rstn      (rstn),
    .stall     (stall),
    .pc_in     (pc_if),
    .instr_in  (instr_if),
    .pc_out    (pc_id),
    .instr_out (instr_id),
    .valid_out (valid_id)
  );

  id_stage #(
    .INSTR_W (INSTR_W)
  ) u_id_stage (
    .instr  (instr_id),
    .opcode (opcode),
    .A      (A),
    .B      (B)
  );

endmodule

// File: tb/tb_if_id_frontend.sv
// Bench for the IF/ID front end: directed scenarios plus randomized stall and
// reset traffic, with expectations queued by the driver and checked by a
// separate monitor on the falling edge.
module tb_if_id_frontend;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic [7:0]  pc_if;
  logic [19:0] instr_if;
  logic [7:0]  pc_id;
  logic [19:0] instr_id;
  logic        valid_id;
  logic [3:0]  opcode;
  logic [7:0]  A;
  logic [7:0]  B;

  typedef struct {
    int pc_if;
    int pc_id;
    int valid_id;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  int   m_pc;
  int   m_pc_id;
  int   m_valid;

  if_id_frontend dut (
    .clk      (clk),
    .rstn     (rstn),
    .stall    (stall),
    .pc_if    (pc_if),
    .instr_if (instr_if),
    .pc_id    (pc_id),
    .instr_id (instr_id),
    .valid_id (valid_id),
    .opcode   (opcode),
    .A        (A),
    .B        (B)
  );

  always #5 clk = ~clk;

  // Expected ROM word at address i, straight from the arithmetic rule.
  function automatic int rom_model(input int i);
    return ((i % 16) * 65536) + (i * 256) + (255 - i);
  endfunction

  function automatic void model_reset();
    m_pc    = 0;
    m_pc_id = 0;
    m_valid = 0;
  endfunction

  // One clock edge of the reference pipeline: last fetched PC moves down.
  function automatic void model_edge(input bit st);
    if (!st) begin
      m_pc_id = m_pc;
      m_valid = 1;
      m_pc    = (m_pc + 1) % 256;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // rctl: 0 = leave reset alone, 1 = assert reset mid-cycle, 2 = release it.
  task automatic applyStimulus(input bit st, input int rctl);
    stall = st;
    @(posedge clk);
    if (rstn) model_edge(st);
    #1;
    if (rctl == 1) begin
      rstn = 1'b0;
      model_reset();
    end else if (rctl == 2) begin
      rstn = 1'b1;
    end
    #1;
    sb_q.push_back('{m_pc, m_pc_id, m_valid});
  endtask

  // Monitor: every expectation queued during a cycle is checked before the
  // next rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   iid;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      iid = (e.valid_id != 0) ? rom_model(e.pc_id) : 0;
      checkOutput("sb_pc_if",    32'(pc_if),    32'(e.pc_if));
      checkOutput("sb_instr_if", 32'(instr_if), 32'(rom_model(e.pc_if)));
      checkOutput("sb_pc_id",    32'(pc_id),    32'(e.pc_id));
      checkOutput("sb_instr_id", 32'(instr_id), 32'(iid));
      checkOutput("sb_valid_id", 32'(valid_id), 32'(e.valid_id));
      checkOutput("sb_opcode",   32'(opcode),   32'((iid / 65536) % 16));
      checkOutput("sb_A",        32'(A),        32'((iid / 256) % 256));
      checkOutput("sb_B",        32'(B),        32'(iid % 256));
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    int rctl;
    rstn  = 1'b0;
    stall = 1'b0;
    model_reset();

    // Reset held: registers zero, ROM still readable at address 0.
    #20;
    checkOutput("rst_pc_if",    32'(pc_if),    32'h0);
    checkOutput("rst_pc_id",    32'(pc_id),    32'h0);
    checkOutput("rst_instr_id", 32'(instr_id), 32'h0);
    checkOutput("rst_valid_id", 32'(valid_id), 32'h0);
    checkOutput("rst_instr_if", 32'(instr_if), 32'h000FF);
    checkOutput("rst_opcode",   32'(opcode),   32'h0);
    #2;
    rstn = 1'b1;

    // Free run for 40 edges.
    repeat (40) applyStimulus(1'b0, 0);
    #2;
    checkOutput("run_pc_if",    32'(pc_if),    32'd40);
    checkOutput("run_instr_if", 32'(instr_if), 32'h828D7);
    checkOutput("run_pc_id",    32'(pc_id),    32'd39);
    checkOutput("run_opcode",   32'(opcode),   32'h7);
    checkOutput("run_A",        32'(A),        32'h27);
    checkOutput("run_B",        32'(B),        32'hD8);

    // Complete 256 edges in total: PC wraps to 0.
    repeat (216) applyStimulus(1'b0, 0);
    #2;
    checkOutput("wrap_pc_if",    32'(pc_if),    32'd0);
    checkOutput("wrap_pc_id",    32'(pc_id),    32'd255);
    checkOutput("wrap_instr_id", 32'(instr_id), 32'hFFF00);

    // Stall for three edges at PC 10, then resume.
    repeat (10) applyStimulus(1'b0, 0);
    #2;
    checkOutput("pre_stall_pc_if", 32'(pc_if), 32'd10);
    repeat (3) applyStimulus(1'b1, 0);
    #2;
    checkOutput("stall_pc_if", 32'(pc_if), 32'd10);
    checkOutput("stall_pc_id", 32'(pc_id), 32'd9);
    applyStimulus(1'b0, 0);
    #2;
    checkOutput("unstall_pc_if", 32'(pc_if), 32'd11);

    // Drop reset mid-cycle at PC 25 and look before the next edge.
    repeat (14) applyStimulus(1'b0, 0);
    #2;
    checkOutput("pre_async_pc_if", 32'(pc_if), 32'd25);
    applyStimulus(1'b1, 1);
    #2;
    checkOutput("async_pc_if",    32'(pc_if),    32'h0);
    checkOutput("async_pc_id",    32'(pc_id),    32'h0);
    checkOutput("async_instr_id", 32'(instr_id), 32'h0);
    checkOutput("async_valid_id", 32'(valid_id), 32'h0);

    // Reset wins over stall; then a stalled first edge keeps valid_id low.
    applyStimulus(1'b1, 0);
    #2;
    checkOutput("rst_stall_pc_if", 32'(pc_if), 32'h0);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b1, 0);
    #2;
    checkOutput("first_stall_valid", 32'(valid_id), 32'h0);
    checkOutput("first_stall_pc_if", 32'(pc_if),    32'h0);
    applyStimulus(1'b0, 0);
    #2;
    checkOutput("first_edge_pc_if",    32'(pc_if),    32'd1);
    checkOutput("first_edge_pc_id",    32'(pc_id),    32'd0);
    checkOutput("first_edge_instr_id", 32'(instr_id), 32'h000FF);
    checkOutput("first_edge_valid",    32'(valid_id), 32'h1);

    // Randomized stall and occasional asynchronous reset traffic.
    for (int i = 0; i < 400; i++) begin
      rctl = 0;
      if (rstn && ($urandom_range(0, 39) == 0)) rctl = 1;
      else if (!rstn && ($urandom_range(0, 2) == 0)) rctl = 2;
      applyStimulus(($urandom_range(0, 3) == 0), rctl);
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
